operand_loader: RTL and testbench

//   Upstream stage of the test-harness arithmetic unit. Collects a serial byte stream
//   (valid/ready) into one BYTES_IN-byte operand frame and hands it downstream as a

---
 rtl/operand_loader_pkg.sv | 21 ++
 rtl/operand_loader_if.sv | 43 ++++
 rtl/operand_loader.sv | 142 ++++++++++++++
 tb/tb_operand_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: state encoding and frame geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package operand_loader_pkg;

   // Default frame geometry: 8 bytes per operand frame.
   localparam int LOG2_BYTES_IN_DEF = 3;

   // CHECK is always part of the encoding so both builds share one enum;
   // it is only reachable when OPERAND_LOADER_CHECKSUM_EN is defined.
   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   function automatic int bytes_in(input int log2_bytes);
      return 1 << log2_bytes;
   endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Handshake bundle between a byte-stream producer / frame consumer and the operand loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the byte side, out_valid/out_ready on the frame side.
//
// Signals:
//   abort      sync frame flush            (to loader)
//   in_data    stream byte                 (to loader)
//   in_valid   in_data valid               (to loader)
//   in_ready   loader accepts a byte       (from loader)
//   out_data   assembled frame, byte 0 LSB (from loader)
//   out_valid  out_data holds a frame      (from loader)
//   out_ready  consumer takes the frame    (to loader)
//   frame_err  dropped-frame pulse         (from loader)
//   frame_cnt  frames delivered mod 256    (from loader)
// Modports: slave = loader view, master = producer/consumer (harness) view.
interface operand_loader_if #(
   parameter int LOG2_BYTES_IN = operand_loader_pkg::LOG2_BYTES_IN_DEF
) ();
   import operand_loader_pkg::*;

   localparam int BYTES_IN = bytes_in(LOG2_BYTES_IN);

   logic                  abort;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [BYTES_IN*8-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  frame_err;
   logic [7:0]            frame_cnt;

   modport slave (
      input  abort, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, frame_err, frame_cnt
   );

   modport master (
      output abort, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, frame_err, frame_cnt
   );

endinterface

// File: rtl/operand_loader.sv
// Assembles a serial byte stream into one BYTES_IN-byte frame and presents it as a wide word.
// Latency: out_valid rises 1 cycle after the last accepted byte (data byte, or checksum byte).
// Backpressure: in_ready low while a frame is held; the frame is held until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; all outputs go to 0 immediately
//   bus    operand_loader_if.slave (byte stream in, frame out, abort, frame_err, frame_cnt)
// Optional feature: define OPERAND_LOADER_CHECKSUM_EN to require a trailing XOR byte per
// frame; a mismatching trailer drops the frame and pulses frame_err for one cycle.
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int LOG2_BYTES_IN = LOG2_BYTES_IN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   operand_loader_if.slave   bus
);

   localparam int BYTES_IN = bytes_in(LOG2_BYTES_IN);
   localparam int W        = BYTES_IN * 8;

   state_e                   state_q, state_d;
   logic [LOG2_BYTES_IN-1:0] idx_q, idx_d;
   logic [W-1:0]             data_q, data_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic                     accept;

`ifdef OPERAND_LOADER_CHECKSUM_EN
   logic [7:0]               xor_q, xor_d;
   logic                     err_q, err_d;
`endif

   // in_ready is registered, so it is still 0 in the first cycle after reset release.
   assign accept = bus.in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef OPERAND_LOADER_CHECKSUM_EN
      xor_d   = xor_q;
      err_d   = 1'b0;
`endif
      if (bus.abort) begin
         // Abort beats any same-cycle accept or frame hand-off; out_data lanes are kept.
         state_d = ST_FILL;
         idx_d   = '0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
         xor_d   = '0;
`endif
      end else begin
         unique case (state_q)
            ST_FILL: begin
               if (accept) begin
                  // Writing straight into the output word: untouched lanes keep the
                  // previous frame's bytes.
                  data_d[{idx_q, 3'b000} +: 8] = bus.in_data;
`ifdef OPERAND_LOADER_CHECKSUM_EN
                  xor_d = xor_q ^ bus.in_data;
`endif
                  if (idx_q == '1) begin
                     idx_d = '0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
                     state_d = ST_CHECK;
`else
                     state_d = ST_HOLD;
`endif
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = ST_FILL;
               end
            end
            ST_CHECK: begin
`ifdef OPERAND_LOADER_CHECKSUM_EN
               if (accept) begin
                  // Either way the next frame starts with a fresh running XOR.
                  xor_d = '0;
                  if (bus.in_data == xor_q) begin
                     state_d = ST_HOLD;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_FILL;
                  end
               end
`else
               state_d = ST_FILL;
`endif
            end
            default: state_d = ST_FILL;
         endcase
      end
   end

   // Handshake outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         idx_q       <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
         xor_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= (state_d != ST_HOLD);
         out_valid_q <= (state_d == ST_HOLD);
`ifdef OPERAND_LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
         err_q       <= err_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign bus.frame_cnt = cnt_q;
`ifdef OPERAND_LOADER_CHECKSUM_EN
   assign bus.frame_err = err_q;
`else
   assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader (LOG2_BYTES_IN=3): vector table, hand-written
// corner sequences, then randomized traffic against a queue-based frame model.
// Follows OPERAND_LOADER_CHECKSUM_EN when defined, appending the XOR trailer byte.
module tb_operand_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   operand_loader_if #(.LOG2_BYTES_IN(3)) bus ();

   operand_loader #(.LOG2_BYTES_IN(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_cnt;

   typedef struct {
      logic [7:0]  b [8];
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the byte until the DUT takes it; bounded so a stuck in_ready cannot hang the run.
   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.in_ready) done = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      if (!done) check("accept_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] b [8]);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 8; i++) x = x ^ b[i];
      return x;
   endfunction

   // Sends one frame; optionally checks out_valid is still low just before the final accept.
   task automatic send_arr(input logic [7:0] b [8], input bit chk_pre);
      for (int i = 0; i < 8; i++) begin
`ifndef OPERAND_LOADER_CHECKSUM_EN
         if (chk_pre && i == 7) check("valid_before_last", 64'(bus.out_valid), 64'd0);
`endif
         send_byte(b[i]);
      end
`ifdef OPERAND_LOADER_CHECKSUM_EN
      if (chk_pre) check("valid_before_last", 64'(bus.out_valid), 64'd0);
      send_byte(xsum(b));
`endif
   endtask

   task automatic send_seq(input logic [7:0] first);
      logic [7:0] b [8];
      for (int i = 0; i < 8; i++) b[i] = first + 8'(i);
      send_arr(b, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.abort     = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      exp_cnt       = 8'h00;

      vecs[0].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      vecs[0].exp = 64'h0807060504030201;
      vecs[1].b = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h80, 8'h01};
      vecs[1].exp = 64'h01805AA500FF00FF;
      vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2].exp = 64'h0000000000000000;
      vecs[3].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
      vecs[3].exp = 64'h78563412EFBEADDE;

      // ---- reset values
      #3;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd0);
      check("rst_frame_err", 64'(bus.frame_err), 64'd0);
      check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
      check("rst_out_data",  bus.out_data,       64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ---- vector table (entry 0 is the basic 01..08 frame)
      for (int v = 0; v < 4; v++) begin
         send_arr(vecs[v].b, 1'b1);
         check("vec_out_valid", 64'(bus.out_valid), 64'd1);
         check("vec_in_ready",  64'(bus.in_ready),  64'd0);
         check("vec_out_data",  bus.out_data,       vecs[v].exp);
         tick();
         exp_cnt++;
         check("vec_frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
         check("vec_released",  64'(bus.out_valid), 64'd0);
         check("vec_frame_err", 64'(bus.frame_err), 64'd0);
      end

      // ---- stall: out_ready low for 5 cycles, a pending byte must not be consumed
      bus.out_ready = 1'b0;
      send_seq(8'h01);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      for (int k = 0; k < 5; k++) begin
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_in_ready",  64'(bus.in_ready),  64'd0);
         check("stall_out_data",  bus.out_data,       64'h0807060504030201);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      exp_cnt++;
      check("stall_release_in_ready", 64'(bus.in_ready),  64'd1);
      check("stall_release_cnt",      64'(bus.frame_cnt), 64'(exp_cnt));

      // ---- abort mid-frame (with a same-cycle byte), then a full frame
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      bus.abort    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h99;
      tick();
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_in_ready",  64'(bus.in_ready),  64'd1);
      check("abort_frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
      send_seq(8'h11);
      check("abort_next_valid", 64'(bus.out_valid), 64'd1);
      check("abort_next_data",  bus.out_data,       64'h1817161514131211);
      // abort while holding, with out_ready high: frame dropped, not counted
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_hold_valid", 64'(bus.out_valid), 64'd0);
      check("abort_hold_cnt",   64'(bus.frame_cnt), 64'(exp_cnt));
      check("abort_hold_ready", 64'(bus.in_ready),  64'd1);
      check("abort_hold_err",   64'(bus.frame_err), 64'd0);

      // ---- asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_data",  bus.out_data,       64'd0);
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_in_ready",  64'(bus.in_ready),  64'd0);
      check("arst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
      tick();
      rst_n   = 1'b1;
      exp_cnt = 8'h00;
      tick();
      send_seq(8'h31);
      check("arst_frame_valid", 64'(bus.out_valid), 64'd1);
      check("arst_frame_data",  bus.out_data,       64'h3837363534333231);
      tick();
      exp_cnt++;
      check("arst_frame_cnt1", 64'(bus.frame_cnt), 64'(exp_cnt));

      // ---- counter wrap: 256 frames since reset bring frame_cnt back to 0
      for (int f = 0; f < 254; f++) begin
         send_seq(8'(f));
         tick();
      end
      exp_cnt = exp_cnt + 8'd254;
      check("wrap_cnt_ff", 64'(bus.frame_cnt), 64'hFF);
      send_seq(8'h40);
      tick();
      exp_cnt++;
      check("wrap_cnt_00", 64'(bus.frame_cnt), 64'h00);

`ifdef OPERAND_LOADER_CHECKSUM_EN
      // ---- bad trailer: dropped frame, single-cycle frame_err
      begin
         logic [7:0] b [8];
         for (int i = 0; i < 8; i++) begin
            b[i] = 8'h01 + 8'(i);
            send_byte(b[i]);
         end
         check("ck_in_ready_check", 64'(bus.in_ready),  64'd1);
         check("ck_valid_check",    64'(bus.out_valid), 64'd0);
         send_byte(8'h00);
         check("ck_err_pulse",   64'(bus.frame_err), 64'd1);
         check("ck_err_novalid", 64'(bus.out_valid), 64'd0);
         tick();
         check("ck_err_cleared", 64'(bus.frame_err), 64'd0);
         check("ck_err_novalid2", 64'(bus.out_valid), 64'd0);
         check("ck_err_cnt",     64'(bus.frame_cnt), 64'(exp_cnt));
         check("ck_err_ready",   64'(bus.in_ready),  64'd1);
         send_arr(b, 1'b0);
         check("ck_good_valid", 64'(bus.out_valid), 64'd1);
         check("ck_good_data",  bus.out_data,       64'h0807060504030201);
         tick();
         exp_cnt++;
      end
`endif

      // ---- randomized traffic against a frame-level model
      begin
         logic [7:0]  part [$];
         bit          holding;
         logic [63:0] hold_word;
         logic        exp_err;
         logic [7:0]  x;
         holding = 1'b0;
         exp_err = 1'b0;
         for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_in_ready",  64'(bus.in_ready),  64'(!holding));
            check("rnd_out_valid", 64'(bus.out_valid), 64'(holding));
            check("rnd_frame_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
            check("rnd_frame_err", 64'(bus.frame_err), 64'(exp_err));
            if (holding) check("rnd_out_data", bus.out_data, hold_word);

            bus.abort     = ($urandom % 40) == 0;
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            bus.in_data   = 8'($urandom);
            x = 8'h00;
            for (int i = 0; i < part.size() && i < 8; i++) x = x ^ part[i];
`ifdef OPERAND_LOADER_CHECKSUM_EN
            if (part.size() == 8 && ($urandom % 4) != 0) bus.in_data = x;
`endif
            exp_err = 1'b0;
            if (bus.abort) begin
               part.delete();
               holding = 1'b0;
            end else if (holding) begin
               if (bus.out_ready) begin
                  holding = 1'b0;
                  exp_cnt++;
               end
            end else if (bus.in_valid) begin
               part.push_back(bus.in_data);
`ifdef OPERAND_LOADER_CHECKSUM_EN
               if (part.size() == 9) begin
                  if (part[8] == x) begin
                     for (int i = 0; i < 8; i++) hold_word[8*i +: 8] = part[i];
                     holding = 1'b1;
                  end else begin
                     exp_err = 1'b1;
                  end
                  part.delete();
               end
`else
               if (part.size() == 8) begin
                  for (int i = 0; i < 8; i++) hold_word[8*i +: 8] = part[i];
                  holding = 1'b1;
                  part.delete();
               end
`endif
            end
            tick();
         end
         bus.abort     = 1'b0;
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
